// File: rtl/fifo_pkg.sv
// Shared constants and pointer type for the asynchronous FIFO read-side logic.
package fifo_pkg;
  localparam int ADDR_W_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int AE_THRESH_DEF   = 1;

  typedef logic [ADDR_W_DEF:0] ptr_t;
endpackage

// File: rtl/bin2gray.sv
// Binary to reflected-Gray converter, purely combinational.
module bin2gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray2bin.sv
// Reflected-Gray to binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end
endmodule

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer chain for a Gray-coded bus; no logic between stages.
module sync_2ff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an async FIFO: read pointer, Gray export, and
// registered empty / almost-empty / occupancy flags from the synchronized write pointer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = AE_THRESH_DEF
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rinc,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rcount,
  output logic              rd_underflow
);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AE_LIM = AE_THRESH[PTR_W-1:0];

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wq_gray;
  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] rcount_next;
  logic             accept;

  sync_2ff #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (wq_gray)
  );

  // Handshake: rinc is a request, ~rempty is the grant; a read is taken
  // only on a cycle where both are high, otherwise it is flagged as underflow.
  assign accept      = rinc & ~rempty;
  assign rbin_next   = rbin + {{ADDR_W{1'b0}}, accept};
  assign rcount_next = wq_bin - rbin_next;

  bin2gray #(.WIDTH(PTR_W)) u_rbin2gray (
    .bin  (rbin_next),
    .gray (rgray_next)
  );

  gray2bin #(.WIDTH(PTR_W)) u_wq2bin (
    .gray (wq_gray),
    .bin  (wq_bin)
  );

  // Flags use the post-read pointer so the last read asserts empty on its own edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rcount        <= '0;
      rd_underflow  <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rgray_next;
      rempty        <= (rgray_next == wq_gray);
      ralmost_empty <= (rcount_next <= AE_LIM);
      rcount        <= rcount_next;
      rd_underflow  <= rinc & rempty;
    end
  end

  assign raddr = rbin[ADDR_W-1:0];
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: FIFO address width; pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop stages on the incoming write pointer; legal values are 2 or more.
REQ-003 SHALL have parameter AE_THRESH, default 1: almost-empty threshold, in entries.
REQ-004 SHALL have port rclk, input, 1 bit: read-domain clock; the block's only clock.
REQ-005 SHALL have port rrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rinc, input, 1 bit: read request.
REQ-007 SHALL have port wptr_gray, input, ADDR_W+1 bits: Gray write pointer from the write domain; asynchronous to rclk.
REQ-008 SHALL have port raddr, output, ADDR_W bits: RAM read address.
REQ-009 SHALL have port rptr_gray, output, ADDR_W+1 bits: registered Gray read pointer sent to the write domain.
REQ-010 SHALL have port rempty, output, 1 bit: FIFO empty, registered.
REQ-011 SHALL have port ralmost_empty, output, 1 bit: occupancy is at most AE_THRESH, registered.
REQ-012 SHALL have port rcount, output, ADDR_W+1 bits: occupancy as seen from the read domain, registered.
REQ-013 SHALL have port rd_underflow, output, 1 bit: one-cycle pulse when a read is requested while empty.

Function
REQ-014 SHALL pass wptr_gray through SYNC_STAGES flops clocked by rclk, giving wq_gray; no logic between the stages.
REQ-015 SHALL accept a read only on a cycle where rinc=1 and rempty=0.
REQ-016 SHALL compute rbin_next = rbin + accept, modulo 2^(ADDR_W+1); it wraps silently.
REQ-017 SHALL drive raddr = rbin[ADDR_W-1:0] from the registered binary pointer.
REQ-018 SHALL register rptr_gray = rbin_next ^ (rbin_next >> 1), so it changes at most one bit per rclk.
REQ-019 SHALL register rempty = (Gray(rbin_next) == wq_gray).
REQ-020 SHALL register rcount = Gray-to-binary(wq_gray) - rbin_next, modulo 2^(ADDR_W+1).
REQ-021 SHALL register ralmost_empty = (rcount_next <= AE_THRESH).
REQ-022 On rinc=1 with rempty=1, SHALL pulse rd_underflow high for exactly one cycle and leave rbin, raddr and rptr_gray unchanged.
REQ-023 SHALL make a write-pointer change visible on rempty and rcount exactly SYNC_STAGES+1 rclk edges after it is stable at wptr_gray.
REQ-024 When the last entry is read, SHALL assert rempty on the same edge that advances rbin (no extra-read window).
REQ-025 When a read and a wq_gray update occur on the same edge, SHALL compute flags from both the new rbin and the new wq_gray.
REQ-026 SHALL keep rempty and rcount pessimistic: stale synchronized data may show the FIFO emptier than it is, never fuller.

Reset
REQ-027 On rrst_n=0, SHALL immediately clear rbin, raddr, rptr_gray, all sync flops, rcount and rd_underflow to 0, and set rempty=1 and ralmost_empty=1.
REQ-028 Reset asserted mid-operation SHALL discard any read in progress; the first read after release starts at raddr=0.
REQ-029 Reset release SHALL be assumed synchronized to rclk upstream; the block contains no reset synchronizer.

Structure
REQ-030 The shared package fifo_pkg SHALL hold the default ADDR_W, SYNC_STAGES and AE_THRESH constants and a ptr_t typedef of width ADDR_W+1.
REQ-031 The synchronizer SHALL be a sub-module sync_2ff, parameterized in WIDTH and STAGES.
REQ-032 The block SHALL instantiate the existing bin2gray and gray2bin converters and SHALL NOT re-implement the conversions.

Verification (ADDR_W=4, SYNC_STAGES=2, AE_THRESH=1)
REQ-033 Reset: assert rrst_n=0 mid-stream -> without waiting for a clock edge, rempty=1, ralmost_empty=1, raddr=0, rptr_gray=00000, rcount=0.
REQ-034 Latency: hold wptr_gray=00010 (3 entries) -> rempty falls and rcount=3 exactly 3 rclk edges later; ralmost_empty=0.
REQ-035 Drain: hold rinc=1 with 3 entries -> raddr steps 0,1,2; rptr_gray steps 00001,00011,00010; rempty=1 on the edge accepting the third read; a fourth rinc produces one rd_underflow pulse with raddr held at 3.
REQ-036 Wrap: preload rbin=15 with wptr_gray=Gray(17) -> one read gives raddr 15->0 and rptr_gray 01000->11000, rcount=1, ralmost_empty=1.
REQ-037 Simultaneous: read the last entry on the same edge wq_gray advances by 1 -> rempty stays 0 and rcount=1.
REQ-038 Assertion: rptr_gray Hamming distance between consecutive cycles is at most 1 for the whole of a random run.
